// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle: stage stall requests, EX multi-cycle handshake,
// exception commit, and the controller's stall/flush/redirect results.
interface pipe_ctrl_if #(
  parameter int unsigned MC_LEN_W = 6,
  parameter int unsigned PERF_W   = 32
);
  logic                stallreq_if;
  logic                stallreq_id;
  logic                stallreq_mem;
  logic                ex_mc_start;
  logic [MC_LEN_W-1:0] ex_mc_len;
  logic                excp_i;
  logic                excp_is_eret;
  logic [31:0]         epc_i;

  logic [5:0]          stall;
  logic                flush;
  logic [31:0]         new_pc;
  logic                ex_mc_done;
  logic                ex_mc_abort;
  logic                mc_err;
  logic [PERF_W-1:0]   stall_cycles;

  modport master (
    output stallreq_if, stallreq_id, stallreq_mem, ex_mc_start, ex_mc_len,
           excp_i, excp_is_eret, epc_i,
    input  stall, flush, new_pc, ex_mc_done, ex_mc_abort, mc_err, stall_cycles
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_mem, ex_mc_start, ex_mc_len,
           excp_i, excp_is_eret, epc_i,
    output stall, flush, new_pc, ex_mc_done, ex_mc_abort, mc_err, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall arbitration, EX multi-cycle countdown,
// exception/eret flush with redirect, and a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter logic [31:0] EXCP_VEC = 32'h0000_0020,
  parameter int unsigned MC_LEN_W = 6,
  parameter int unsigned PERF_W   = 32
) (
  input  logic      clk,
  input  logic      rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]          state_q;
  logic [MC_LEN_W-1:0] cnt_q;
  logic                mc_err_q;
  logic [PERF_W-1:0]   perf_q;

  logic                in_run;
  logic                in_busy;
  logic                len_multi;
  logic                ex_busy;
  logic                done_c;
  logic [5:0]          stall_c;
  logic                flush_c;
  logic [31:0]         new_pc_c;
  logic                abort_c;

  assign in_run    = (state_q == ST_RUN);
  assign in_busy   = (state_q == ST_BUSY);
  assign len_multi = |bus.ex_mc_len[MC_LEN_W-1:1];

  always_comb begin
    ex_busy  = 1'b0;
    done_c   = 1'b0;
    stall_c  = '0;
    flush_c  = 1'b0;
    new_pc_c = '0;
    abort_c  = 1'b0;
    if (!rst) begin
      if (bus.excp_i) begin
        flush_c  = 1'b1;
        new_pc_c = bus.excp_is_eret ? bus.epc_i : EXCP_VEC;
        abort_c  = in_busy;
      end else begin
        if (in_run && bus.ex_mc_start) begin
          ex_busy = len_multi;
          done_c  = !len_multi;
        end else if (in_busy) begin
          ex_busy = (cnt_q != '0);
          done_c  = (cnt_q == '0);
        end
        if (bus.stallreq_mem)     stall_c = 6'b011111;
        else if (ex_busy)         stall_c = 6'b001111;
        else if (bus.stallreq_id) stall_c = 6'b000111;
        else if (bus.stallreq_if) stall_c = 6'b000011;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      mc_err_q <= 1'b0;
      perf_q   <= '0;
    end else begin
      if (in_busy && bus.ex_mc_start)
        mc_err_q <= 1'b1;
      if (stall_c[0] && !(&perf_q))
        perf_q <= perf_q + PERF_W'(1);

      if (bus.excp_i) begin
        state_q <= ST_RUN;
        cnt_q   <= '0;
      end else if (in_run) begin
        if (bus.ex_mc_start && len_multi) begin
          state_q <= ST_BUSY;
          cnt_q   <= bus.ex_mc_len - MC_LEN_W'(2);
        end
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - MC_LEN_W'(1);
      end else if (!bus.stallreq_mem) begin
        // Result stays presented (done held) until MEM lets the pipe advance.
        state_q <= ST_RUN;
      end
    end
  end

  assign bus.stall        = stall_c;
  assign bus.flush        = flush_c;
  assign bus.new_pc       = new_pc_c;
  assign bus.ex_mc_done   = done_c;
  assign bus.ex_mc_abort  = abort_c;
  assign bus.mc_err       = rst ? 1'b0 : mc_err_q;
  assign bus.stall_cycles = rst ? '0 : perf_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl plus hand sequences for
// mc_err, reset during a multi-cycle op, and counter saturation.
module tb_pipe_ctrl;

  localparam int unsigned MC_LEN_W = 6;
  localparam int unsigned PERF_W   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.MC_LEN_W(MC_LEN_W), .PERF_W(PERF_W)) bus ();

  pipe_ctrl #(
    .EXCP_VEC(32'h0000_0020),
    .MC_LEN_W(MC_LEN_W),
    .PERF_W  (PERF_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string       nm;
    logic        rst, sif, sid, smem, start;
    logic [5:0]  len;
    logic        excp, eret;
    logic [31:0] epc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_done, e_abort;
    int unsigned e_perf;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(string nm, logic r, logic sif, logic sid, logic smem,
                              logic st, logic [5:0] len, logic ex, logic er,
                              logic [31:0] epc, logic [5:0] es, logic ef,
                              logic [31:0] ep, logic ed, logic ea, int unsigned eperf);
    vec_t v;
    v.nm = nm; v.rst = r; v.sif = sif; v.sid = sid; v.smem = smem; v.start = st;
    v.len = len; v.excp = ex; v.eret = er; v.epc = epc;
    v.e_stall = es; v.e_flush = ef; v.e_pc = ep; v.e_done = ed; v.e_abort = ea;
    v.e_perf = eperf;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic set_in(logic r, logic sif, logic sid, logic smem, logic st,
                        logic [5:0] len, logic ex, logic er, logic [31:0] epc);
    rst              = r;
    bus.stallreq_if  = sif;
    bus.stallreq_id  = sid;
    bus.stallreq_mem = smem;
    bus.ex_mc_start  = st;
    bus.ex_mc_len    = len;
    bus.excp_i       = ex;
    bus.excp_is_eret = er;
    bus.epc_i        = epc;
  endtask

  // One cycle: drive just after the edge, then sit at the falling edge to sample.
  task automatic cyc(logic r, logic sif, logic sid, logic smem, logic st,
                     logic [5:0] len, logic ex, logic er, logic [31:0] epc);
    @(posedge clk);
    #1;
    set_in(r, sif, sid, smem, st, len, ex, er, epc);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_rst();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0);

    //                  rst if id mem st len   ex er epc           stall   fl pc            dn ab perf
    vecs.push_back(mk("rst0",   1,1,1,1,1,6'd5, 1,1,32'hFFFF_FFFF, 6'h00, 0,32'h0,        0,0,0));
    vecs.push_back(mk("rst1",   1,1,1,1,1,6'd5, 1,0,32'hFFFF_FFFF, 6'h00, 0,32'h0,        0,0,0));
    vecs.push_back(mk("idle",   0,0,0,0,0,6'd0, 0,0,32'h0,         6'h00, 0,32'h0,        0,0,0));
    vecs.push_back(mk("id_mem", 0,0,1,1,0,6'd0, 0,0,32'h0,         6'h1F, 0,32'h0,        0,0,0));
    vecs.push_back(mk("if",     0,1,0,0,0,6'd0, 0,0,32'h0,         6'h03, 0,32'h0,        0,0,1));
    vecs.push_back(mk("id",     0,0,1,0,0,6'd0, 0,0,32'h0,         6'h07, 0,32'h0,        0,0,2));
    vecs.push_back(mk("excp",   0,1,1,1,0,6'd0, 1,0,32'h5555_0000, 6'h00, 1,32'h20,       0,0,3));
    vecs.push_back(mk("eret_st",0,0,0,0,1,6'd5, 1,1,32'h0000_1234, 6'h00, 1,32'h0000_1234,0,0,3));
    vecs.push_back(mk("no_busy",0,0,0,0,0,6'd0, 0,0,32'h0,         6'h00, 0,32'h0,        0,0,3));
    vecs.push_back(mk("l5_t0",  0,0,0,0,1,6'd5, 0,0,32'h0,         6'h0F, 0,32'h0,        0,0,3));
    vecs.push_back(mk("l5_t1",  0,0,0,0,0,6'd0, 0,0,32'h0,         6'h0F, 0,32'h0,        0,0,4));
    vecs.push_back(mk("l5_t2",  0,0,0,0,0,6'd0, 0,0,32'h0,         6'h0F, 0,32'h0,        0,0,5));
    vecs.push_back(mk("l5_t3",  0,0,0,0,0,6'd0, 0,0,32'h0,         6'h0F, 0,32'h0,        0,0,6));
    vecs.push_back(mk("l5_t4",  0,0,0,0,0,6'd0, 0,0,32'h0,         6'h00, 0,32'h0,        1,0,7));
    vecs.push_back(mk("l5_t5",  0,0,0,0,0,6'd0, 0,0,32'h0,         6'h00, 0,32'h0,        0,0,7));
    vecs.push_back(mk("l1",     0,0,0,0,1,6'd1, 0,0,32'h0,         6'h00, 0,32'h0,        1,0,7));
    vecs.push_back(mk("l0",     0,0,0,0,1,6'd0, 0,0,32'h0,         6'h00, 0,32'h0,        1,0,7));
    vecs.push_back(mk("l0_idle",0,0,0,0,0,6'd0, 0,0,32'h0,         6'h00, 0,32'h0,        0,0,7));
    vecs.push_back(mk("l4_t0",  0,0,0,0,1,6'd4, 0,0,32'h0,         6'h0F, 0,32'h0,        0,0,7));
    vecs.push_back(mk("l4_t1",  0,0,0,0,0,6'd0, 0,0,32'h0,         6'h0F, 0,32'h0,        0,0,8));
    vecs.push_back(mk("l4_t2",  0,0,0,1,0,6'd0, 0,0,32'h0,         6'h1F, 0,32'h0,        0,0,9));
    vecs.push_back(mk("l4_t3",  0,0,0,1,0,6'd0, 0,0,32'h0,         6'h1F, 0,32'h0,        1,0,10));
    vecs.push_back(mk("l4_t4",  0,0,0,1,0,6'd0, 0,0,32'h0,         6'h1F, 0,32'h0,        1,0,11));
    vecs.push_back(mk("l4_t5",  0,0,0,0,0,6'd0, 0,0,32'h0,         6'h00, 0,32'h0,        1,0,12));
    vecs.push_back(mk("l4_t6",  0,0,0,0,0,6'd0, 0,0,32'h0,         6'h00, 0,32'h0,        0,0,12));
    vecs.push_back(mk("l6_t0",  0,0,0,0,1,6'd6, 0,0,32'h0,         6'h0F, 0,32'h0,        0,0,12));
    vecs.push_back(mk("l6_eret",0,0,0,0,0,6'd0, 1,1,32'h0000_1234, 6'h00, 1,32'h0000_1234,0,1,13));
    vecs.push_back(mk("l6_post",0,0,0,0,0,6'd0, 0,0,32'h0,         6'h00, 0,32'h0,        0,0,13));
    vecs.push_back(mk("l2_t0",  0,0,0,0,1,6'd2, 0,0,32'h0,         6'h0F, 0,32'h0,        0,0,13));
    vecs.push_back(mk("l2_excp",0,0,0,0,0,6'd0, 1,0,32'h0000_1234, 6'h00, 1,32'h20,       0,1,14));
    vecs.push_back(mk("l2_post",0,0,0,0,0,6'd0, 0,0,32'h0,         6'h00, 0,32'h0,        0,0,14));
    vecs.push_back(mk("ex_st1", 0,0,0,0,1,6'd1, 1,0,32'h0,         6'h00, 1,32'h20,       0,0,14));
    vecs.push_back(mk("ex_post",0,0,0,0,0,6'd0, 0,0,32'h0,         6'h00, 0,32'h0,        0,0,14));

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      cyc(v.rst, v.sif, v.sid, v.smem, v.start, v.len, v.excp, v.eret, v.epc);
      chk({v.nm, ".stall"},  32'(bus.stall),        32'(v.e_stall));
      chk({v.nm, ".flush"},  32'(bus.flush),        32'(v.e_flush));
      chk({v.nm, ".new_pc"}, bus.new_pc,            v.e_pc);
      chk({v.nm, ".done"},   32'(bus.ex_mc_done),   32'(v.e_done));
      chk({v.nm, ".abort"},  32'(bus.ex_mc_abort),  32'(v.e_abort));
      chk({v.nm, ".perf"},   32'(bus.stall_cycles), v.e_perf);
    end

    // Restart attempt while busy: ignored, done timing kept, mc_err sticky.
    do_rst();
    idle();
    chk("err.perf0", 32'(bus.stall_cycles), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 1'b0, 1'b0, 32'h0);
    chk("err.t0.stall", 32'(bus.stall), 32'h0F);
    idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 1'b0, 32'h0);
    chk("err.t2.stall", 32'(bus.stall), 32'h0F);
    chk("err.t2.done",  32'(bus.ex_mc_done), 32'd0);
    chk("err.t2.err",   32'(bus.mc_err), 32'd0);
    idle();
    chk("err.t3.stall", 32'(bus.stall), 32'h0F);
    chk("err.t3.done",  32'(bus.ex_mc_done), 32'd0);
    chk("err.t3.err",   32'(bus.mc_err), 32'd1);
    idle();
    chk("err.t4.done",  32'(bus.ex_mc_done), 32'd1);
    chk("err.t4.stall", 32'(bus.stall), 32'h00);
    idle();
    chk("err.t5.done",  32'(bus.ex_mc_done), 32'd0);
    chk("err.t5.err",   32'(bus.mc_err), 32'd1);
    do_rst();
    chk("err.rst.err",  32'(bus.mc_err), 32'd0);
    idle();
    chk("err.clr.err",  32'(bus.mc_err), 32'd0);

    // Reset mid-op drops to RUN silently, even with an exception pending.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd6, 1'b0, 1'b0, 32'h0);
    idle();
    chk("rbusy.t1.stall", 32'(bus.stall), 32'h0F);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0);
    chk("rbusy.abort", 32'(bus.ex_mc_abort), 32'd0);
    chk("rbusy.flush", 32'(bus.flush), 32'd0);
    chk("rbusy.stall", 32'(bus.stall), 32'h00);
    idle();
    chk("rbusy.run.stall", 32'(bus.stall), 32'h00);
    chk("rbusy.run.done",  32'(bus.ex_mc_done), 32'd0);

    // Counter saturation at all-ones.
    do_rst();
    for (int i = 0; i < 254; i++)
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
    idle();
    chk("sat.254", 32'(bus.stall_cycles), 32'd254);
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h0);
    idle();
    chk("sat.max", 32'(bus.stall_cycles), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencing controller for the 5-stage core.
- Arbitrates stall requests from IF/ID/EX/MEM into the per-stage stall vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb registers.
- Sequences multi-cycle EX operations (div, madd) with an internal countdown, so EX does not drive stall itself.
- Issues the exception/eret flush and redirect PC, and keeps a saturating stall-cycle performance counter.

Parameters:
EXCP_VEC, 32'h00000020, redirect target for general exceptions
MC_LEN_W, 6, width of multi-cycle length field
PERF_W, 32, width of stall-cycle counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high (`Enable); sampled on posedge clk
stallreq_if  input  1  IF stall request
stallreq_id  input  1  ID stall request (load-use)
stallreq_mem  input  1  MEM stall request
ex_mc_start  input  1  one-cycle pulse: EX begins a multi-cycle op
ex_mc_len  input  MC_LEN_W  total EX cycles of that op, sampled with start
excp_i  input  1  exception/eret commit from MEM
excp_is_eret  input  1  qualifies excp_i as eret
epc_i  input  32  return address for eret
stall  output  6  [0]=pc [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB
flush  output  1  clear all pipeline registers at next edge
new_pc  output  32  redirect address, valid when flush=1
ex_mc_done  output  1  EX multi-cycle result valid this cycle
ex_mc_abort  output  1  in-flight multi-cycle op killed by flush
mc_err  output  1  sticky: start seen outside RUN
stall_cycles  output  PERF_W  saturating count of cycles with stall[0]=1

Behaviour:
- State register: RUN, BUSY. Counter cnt (MC_LEN_W). stall, flush, new_pc, ex_mc_done and ex_mc_abort are combinational from inputs and state; state, cnt, mc_err and stall_cycles are registered.
- While rst=1, all outputs are 0. At the clock edge: state=RUN, cnt=0, mc_err=0, stall_cycles=0.
- Stall priority, highest first:
  - excp_i: stall=0, flush=1.
  - stallreq_mem: 6'b011111.
  - EX busy: 6'b001111.
  - stallreq_id: 6'b000111.
  - stallreq_if: 6'b000011.
  - none: 6'b000000.
- flush is asserted only when excp_i=1. new_pc = epc_i if excp_is_eret, else EXCP_VEC. new_pc = 0 when flush=0.
- Multi-cycle start, in RUN with ex_mc_start=1 and excp_i=0:
  - len<=1: ex_mc_done=1 in the same cycle; no EX busy; stay RUN.
  - len>=2: EX busy this cycle; next state BUSY with cnt=len-2.
  - Net effect: EX busy (stall) for len-1 cycles; ex_mc_done in the final (len-th) cycle.
- In BUSY:
  - cnt!=0: EX busy; cnt decrements each cycle, including while MEM stalls.
  - cnt==0: ex_mc_done=1 and EX busy released.
  - If stallreq_mem=1 at cnt==0: stay BUSY, keep ex_mc_done=1 each cycle. Go to RUN on the first cycle with stallreq_mem=0.
- excp_i in BUSY: ex_mc_abort=1, ex_mc_done=0, flush=1, next state RUN, cnt=0.
- excp_i together with ex_mc_start in RUN: start is ignored and ex_mc_abort=0.
- ex_mc_start while in BUSY: ignored (no restart); mc_err set at the next edge and held until rst.
- stall_cycles: +1 at each edge where stall[0]=1 and rst=0; saturates at all-ones with no wrap.
- rst mid-BUSY: at the next edge the op is dropped to RUN without ex_mc_abort (all outputs are held 0 during rst).

Test Plan:
- rst=1 for 2 cycles with all requests high -> all outputs 0; after release with no requests, stall=000000 and stall_cycles=0.
- stallreq_id=1 and stallreq_mem=1 together -> stall=011111. Then only stallreq_if -> 000011. stall_cycles increments by 1 per stalled cycle.
- ex_mc_start, len=5, no other requests -> stall=001111 for cycles T..T+3; ex_mc_done=1 at T+4 with stall=0; state RUN at T+5. Repeat with len=1 -> done at T with no stall.
- len=4 with stallreq_mem=1 during T+2..T+4 -> done at T+3 and T+4 with stall=011111; RUN at T+5.
- excp_i (eret, epc_i=32'h0000_1234) at T+1 of a len=6 op -> flush=1, new_pc=32'h0000_1234, ex_mc_abort=1, stall=0; RUN next cycle. Non-eret excp -> new_pc=32'h20.
- Second ex_mc_start during BUSY -> no restart, original done timing unchanged, mc_err=1 until rst. Force stall_cycles near max -> saturates at all-ones.
